// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin grant.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [CHANNELS-1:0]       in_last,
   output logic                      out_last,
`endif
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SELW-1:0]           out_chan
);

   logic [WIDTH-1:0] chan_data [CHANNELS];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
         assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;

   logic [SELW-1:0]  rr_grant;
   logic             rr_found;
   logic [SELW-1:0]  scan_idx;
   logic [SELW-1:0]  grant;
   logic             grant_any;
   logic             load_en;
   logic             in_xfer;
   logic             locked;

`ifdef STREAM_MUX_PKT_LOCK_EN
   typedef enum logic {IDLE, LOCKED} lock_state_t;
   lock_state_t      state_q, state_d;
   logic [SELW-1:0]  lock_chan_q, lock_chan_d;
   logic             out_last_q, out_last_d;

   assign locked = (state_q == LOCKED);
`else
   assign locked = 1'b0;
`endif

   // Scan ptr+1, ptr+2, ... ; CHANNELS is a power of two so SELW-bit addition wraps naturally.
   always_comb begin
      rr_grant = '0;
      rr_found = 1'b0;
      scan_idx = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         scan_idx = ptr_q + SELW'(i);
         if (!rr_found && in_valid[scan_idx]) begin
            rr_grant = scan_idx;
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      grant     = sel;
      grant_any = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (locked) begin
         grant     = lock_chan_q;
         grant_any = 1'b1;
      end else
`endif
      if (mode) begin
         grant     = rr_grant;
         grant_any = rr_found;
      end
   end

   assign load_en = !out_valid_q || out_ready;

   always_comb begin
      in_ready = '0;
      if (!rst && grant_any && load_en)
         in_ready[grant] = 1'b1;
   end

   assign in_xfer = in_valid[grant] && in_ready[grant];

   always_comb begin
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_chan_d  = out_chan_q;
      if (in_xfer) begin
         out_data_d  = chan_data[grant];
         out_valid_d = 1'b1;
         out_chan_d  = grant;
         if (mode)
            ptr_d = grant;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   always_comb begin
      state_d     = state_q;
      lock_chan_d = lock_chan_q;
      out_last_d  = out_last_q;
      if (in_xfer) begin
         out_last_d = in_last[grant];
         case (state_q)
            IDLE: begin
               if (!in_last[grant]) begin
                  state_d     = LOCKED;
                  lock_chan_d = grant;
               end
            end
            LOCKED: begin
               if (in_last[grant])
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lock_chan_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_chan_q <= lock_chan_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_last = out_last_q;
`endif

   // Reset leaves ptr at the last channel so channel 0 wins the first round-robin scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= SELW'(CHANNELS - 1);
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_chan  = out_chan_q;

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, input channel count, power of two, 2..16.
REQ-003 Parameter SELW, default $clog2(CHANNELS), channel index width; not overridden by users.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed in REQ-005 and REQ-006.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel data valid.
REQ-009 in_ready  output  CHANNELS  per-channel accept, combinational.
REQ-010 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-011 sel  input  SELW  selected channel in mode 0; ignored in mode 1.
REQ-012 out_data  output  WIDTH  registered output data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_chan  output  SELW  registered source channel index of out_data.

Function
REQ-016 Transfer on a port SHALL occur when valid and ready are both 1 on a rising clk edge.
REQ-017 load_en SHALL equal (!out_valid || out_ready); the output register loads only when load_en=1 and the granted channel is valid.
REQ-018 Mode 0: grant = sel; in_ready[sel] = load_en; all other in_ready = 0.
REQ-019 Mode 1: grant = first channel with in_valid=1 scanning ptr+1, ptr+2, ... modulo CHANNELS; in_ready[grant] = load_en; others 0; no valid channel -> all in_ready = 0.
REQ-020 ptr SHALL update to grant only on an input transfer in mode 1; ptr SHALL be held in mode 0.
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid=1; throughput SHALL be one beat per cycle with out_ready held at 1.
REQ-022 An output transfer with no new load SHALL clear out_valid; a simultaneous output transfer and load SHALL keep out_valid=1 with the new data.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_valid and out_chan SHALL hold regardless of changes to mode, sel or the inputs.
REQ-024 Changes to mode or sel SHALL affect only the next grant; no beat SHALL be dropped or duplicated.
REQ-025 in_ready SHALL never be asserted on more than one channel in the same cycle.

Reset
REQ-026 With rst=1 at a clk edge: out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (channel 0 has first priority), lock state=IDLE.
REQ-027 During rst=1, all in_ready SHALL be 0; reset mid-stream SHALL discard the held beat.

Configuration
REQ-028 Macro STREAM_MUX_PKT_LOCK_EN: when defined, ports in_last (input, CHANNELS) and out_last (output, 1, registered with out_data, reset 0) SHALL exist.
REQ-029 With STREAM_MUX_PKT_LOCK_EN defined: FSM IDLE -> LOCKED on an input transfer with in_last=0; LOCKED -> IDLE on an input transfer with in_last=1; in LOCKED, grant SHALL be the locked channel in both modes, ignoring sel and ptr.
REQ-030 Without the macro: no last ports and no FSM; arbitration is per beat as in REQ-018 to REQ-020.

Verification
REQ-031 Mode 1, CHANNELS=4, all in_valid=1, out_ready=1 for 8 cycles after reset -> out_chan sequence 0,1,2,3,0,1,2,3, one per cycle.
REQ-032 Mode 0, sel=2, in_data ch2=0xA5, in_valid=4'b0100 -> out_data=0xA5 and out_chan=2 one cycle later; in_ready=4'b0100 only.
REQ-033 out_valid=1 with out_ready=0 for 3 cycles, with sel toggling and in_valid all 1 -> out_data stable and in_ready=0 throughout; on release, the next beat loads in the same cycle.
REQ-034 rst=1 asserted while out_valid=1 -> next cycle out_valid=0, out_chan=0; first round-robin grant after reset is channel 0.
REQ-035 With STREAM_MUX_PKT_LOCK_EN, mode 1: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 stay valid -> out_chan=1,1,1, then 2.
